// File: rtl/xrad_ai_job_feeder.sv
// Initiator side of the XRAD AI channel: gathers 4-word jobs from a stream, launches them,
// waits on the accelerator busy handshake with a timeout and queues results in a FIFO.
module xrad_ai_job_feeder #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [3:0]  ch_valid,
    output logic [31:0] ch_data0,
    output logic [31:0] ch_data1,
    output logic [31:0] ch_data2,
    output logic [31:0] ch_data3,
    input  logic        ai_busy,
    input  logic [31:0] ai_result,
    input  logic        ai_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        err_timeout,
    output logic [15:0] job_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_ARM,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_in_ready;
    logic [1:0]    r_idx;
    logic [31:0]   r_data [4];
    logic [TW-1:0] r_tmo;
    logic          r_err;
    logic [15:0]   r_job_cnt;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_abort;
    logic w_tmo_hit;
    logic w_unused_ai_done;

    // Completion keys off busy falling; the accelerator's sticky done flag is not needed.
    assign w_unused_ai_done = ai_done;

    assign w_accept  = in_valid && r_in_ready;
    assign w_pop     = (r_count != '0) && out_ready;
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_COLLECT;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == S_COLLECT);
        end
    end

    // Next-state decode; completion takes priority over a coincident timeout.
    always_comb begin
        w_next  = r_state;
        w_push  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            S_COLLECT: begin
                if (w_accept && (r_idx == 2'd3)) w_next = S_ARM;
            end
            S_ARM: begin
                if (r_count < CW'(DEPTH)) w_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (w_tmo_hit) begin
                    w_abort = 1'b1;
                    w_next  = S_COLLECT;
                end else if (ai_busy) begin
                    w_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!ai_busy) begin
                    w_push = 1'b1;
                    w_next = S_COLLECT;
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                    w_next  = S_COLLECT;
                end
            end
            default: w_next = S_COLLECT;
        endcase
    end

    // Job word capture; the channel data only moves on accepted words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
            for (int i = 0; i < 4; i++) r_data[i] <= '0;
        end else if (w_accept) begin
            r_data[r_idx] <= in_data;
            r_idx         <= r_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo     <= '0;
            r_err     <= 1'b0;
            r_job_cnt <= '0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_tmo <= '0;
            end else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_abort) r_err <= 1'b1;
            if (w_push) r_job_cnt <= r_job_cnt + 16'd1;
        end
    end

    // Result FIFO; ARM guarantees a push never lands on a full queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= ai_result;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign ch_valid    = {4{r_state == S_LAUNCH}};
    assign ch_data0    = r_data[0];
    assign ch_data1    = r_data[1];
    assign ch_data2    = r_data[2];
    assign ch_data3    = r_data[3];
    assign out_valid   = (r_count != '0);
    assign out_data    = r_mem[r_rptr];
    assign err_timeout = r_err;
    assign job_count   = r_job_cnt;

endmodule
